// File: rtl/cpu_mem_pkg.sv
// Memory-side encodings shared by the BRAM arbiter and the future cache/MMIO decoders.
package cpu_mem_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_NONE = 2'd0;
  localparam owner_t OWNER_IF   = 2'd1;
  localparam owner_t OWNER_D    = 2'd2;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/bram_spram.sv
// Single-port block RAM: one-cycle registered read, write-first on a write.
module bram_spram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_en,
  input  logic [WIDTH-1:0]  write_data,
  output logic [WIDTH-1:0]  read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[address] <= write_data;
      read_data    <= write_data;
    end else begin
      read_data <= mem[address];
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between instruction fetch and load/store.
// Data wins by default; a starvation counter forces IF through after STARVE_LIMIT D grants.
module bram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [31:0]      mem_address,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  owner_t                  resp_owner;

  // Grants are suppressed while reset is asserted so the RAM sees no write.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (d_req && !(if_req && (starve_cnt == LIMIT))) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign mem_address    = if_gnt ? if_addr : d_addr;
  assign mem_write_en   = d_gnt & d_we;
  assign mem_write_data = d_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= OWNER_NONE;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt;
      if (if_gnt) begin
        resp_owner <= OWNER_IF;
      end else if (d_gnt) begin
        resp_owner <= OWNER_D;
      end else begin
        resp_owner <= OWNER_NONE;
      end
      if (if_gnt || !if_req) begin
        starve_cnt <= '0;
      end else if (d_gnt && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // The RAM output register already holds the response; only route it to its owner.
  assign if_rdata = (resp_owner == OWNER_IF) ? mem_read_data : '0;
  assign d_rdata  = (resp_owner == OWNER_D)  ? mem_read_data : '0;

endmodule
